// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with INC/BRANCH/JUMP/CALL/RET and a circular return-address stack.
// Define PC_SEQ_HISTORY_EN to record the pc of the last taken transfer on last_src.
module pc_sequencer #(
    parameter int          PC_W      = 12,
    parameter int          OFF_W     = 8,
    parameter int          RAS_DEPTH = 4,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [2:0]       op,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus1,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf,
    output logic [PC_W-1:0]  last_src
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [2:0] OP_INC = 3'd0, OP_BRANCH = 3'd1, OP_JUMP = 3'd2, OP_CALL = 3'd3, OP_RET = 3'd4;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  stack_q [RAS_DEPTH];
    logic [PC_W-1:0]  stack_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [PC_W-1:0]  br_off;

    assign pc        = pc_q;
    assign pc_plus1  = pc_q + 1'b1;
    assign ras_empty = cnt_q == '0;
    assign ras_full  = cnt_q == CNT_W'(RAS_DEPTH);
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
    assign br_off    = PC_W'($signed(offset));

    // ptr_q is the next write slot; a push while full lands on the oldest entry.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;
        if (Enable) begin
            case (op)
                OP_INC:    pc_d = pc_plus1;
                OP_BRANCH: pc_d = pc_q + br_off;
                OP_JUMP:   pc_d = target;
                OP_CALL: begin
                    stack_d[ptr_q] = pc_plus1;
                    ptr_d          = ptr_q + 1'b1;
                    pc_d           = target;
                    cnt_d          = ras_full ? cnt_q : cnt_q + 1'b1;
                    ovf_d          = ovf_q | ras_full;
                end
                OP_RET: begin
                    pc_d  = ras_empty ? pc_plus1 : stack_q[ptr_q - 1'b1];
                    ptr_d = ras_empty ? ptr_q : ptr_q - 1'b1;
                    cnt_d = ras_empty ? cnt_q : cnt_q - 1'b1;
                    unf_d = unf_q | ras_empty;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q  <= PC_W'(RESET_VEC);
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
        stack_q <= stack_d;
    end

`ifdef PC_SEQ_HISTORY_EN
    logic [PC_W-1:0] last_src_q, last_src_d;
    always_comb begin
        last_src_d = last_src_q;
        if (Enable && (op == OP_BRANCH || op == OP_JUMP || op == OP_CALL || (op == OP_RET && !ras_empty)))
            last_src_d = pc_q;
    end
    always_ff @(posedge Clock) begin
        if (Reset) last_src_q <= '0;
        else       last_src_q <= last_src_d;
    end
    assign last_src = last_src_q;
`else
    assign last_src = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; a queue-and-integer reference model feeds expected state to a monitor.
module tb_pc_sequencer;
    localparam int DEPTH = 4;
    localparam int MASK  = 12'hFFF;
    localparam int RV    = 12'h010;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0, Enable = 1'b0;
    logic [2:0]  op = '0;
    logic [7:0]  offset = '0;
    logic [11:0] target = '0;
    logic [11:0] pc, pc_plus1, last_src;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;

    pc_sequencer #(.PC_W(12), .OFF_W(8), .RAS_DEPTH(DEPTH), .RESET_VEC(RV)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .op(op), .offset(offset), .target(target),
        .pc(pc), .pc_plus1(pc_plus1), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf), .last_src(last_src)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [11:0] pc, pp1, ls;
        logic        emp, full, ovf, unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;

    int m_pc = 0, m_ls = 0;
    int m_stk[$];
    bit m_ovf = 0, m_unf = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: every observed cycle with an outstanding expectation is compared.
    initial forever begin
        @(negedge Clock);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus1", pc_plus1, e.pp1);
            chk("ras_empty", 12'(ras_empty), 12'(e.emp));
            chk("ras_full", 12'(ras_full), 12'(e.full));
            chk("ras_ovf", 12'(ras_ovf), 12'(e.ovf));
            chk("ras_unf", 12'(ras_unf), 12'(e.unf));
            chk("last_src", last_src, e.ls);
        end
    end

    task automatic step(input bit r, input bit en, input logic [2:0] o, input logic [7:0] off, input logic [11:0] tgt);
        exp_t e;
        @(negedge Clock);
        Reset = r; Enable = en; op = o; offset = off; target = tgt;
        if (r) begin
            m_pc = RV; m_stk.delete(); m_ovf = 0; m_unf = 0; m_ls = 0;
        end else if (en) begin
            case (o)
                3'd0: m_pc = (m_pc + 1) & MASK;
                3'd1: begin m_ls = m_pc; m_pc = (m_pc + int'($signed(off))) & MASK; end
                3'd2: begin m_ls = m_pc; m_pc = int'(tgt); end
                3'd3: begin
                    m_ls = m_pc;
                    if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); m_ovf = 1; end
                    m_stk.push_back((m_pc + 1) & MASK);
                    m_pc = int'(tgt);
                end
                3'd4: begin
                    if (m_stk.size() > 0) begin m_ls = m_pc; m_pc = m_stk.pop_back(); end
                    else begin m_pc = (m_pc + 1) & MASK; m_unf = 1; end
                end
                default: ;
            endcase
        end
        e.pc   = 12'(m_pc);
        e.pp1  = 12'((m_pc + 1) & MASK);
        e.emp  = m_stk.size() == 0;
        e.full = m_stk.size() == DEPTH;
        e.ovf  = m_ovf;
        e.unf  = m_unf;
`ifdef PC_SEQ_HISTORY_EN
        e.ls   = 12'(m_ls);
`else
        e.ls   = 12'h000;
`endif
        @(posedge Clock);
        #1 exp_q.push_back(e);
    endtask

    initial begin
        step(1, 0, 3'd0, 8'h00, 12'h000);
        step(0, 1, 3'd2, 8'h00, 12'hFFE);
        repeat (3) step(0, 1, 3'd0, 8'h00, 12'h000);
        step(0, 1, 3'd2, 8'h00, 12'h100);
        step(0, 1, 3'd1, 8'h80, 12'h000);
        step(0, 1, 3'd1, 8'h7F, 12'h000);
        step(0, 1, 3'd1, 8'h00, 12'h000);
        step(0, 1, 3'd2, 8'h00, 12'h002);
        step(0, 1, 3'd1, 8'hFD, 12'h000);
        step(0, 1, 3'd2, 8'h00, 12'h020);
        step(0, 1, 3'd3, 8'h00, 12'h300);
        step(0, 1, 3'd3, 8'h00, 12'h400);
        repeat (2) step(0, 1, 3'd4, 8'h00, 12'h000);
        for (int i = 0; i < 5; i++) step(0, 1, 3'd3, 8'h00, 12'(12'h700 + 12'(i * 16)));
        repeat (5) step(0, 1, 3'd4, 8'h00, 12'h000);
        for (int i = 5; i <= 7; i++) step(0, 1, 3'(i), 8'h11, 12'h222);
        step(0, 0, 3'd2, 8'h00, 12'h555);
        step(0, 0, 3'd3, 8'h00, 12'h555);
        step(1, 1, 3'd3, 8'h00, 12'h666);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                 8'($urandom), 12'($urandom));
        repeat (2) @(negedge Clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
